// File: rtl/rv_exec_ctrl.sv
// rv_exec_ctrl: RV32I execute/control core.
//   Three-state sequencing FSM (RESET -> FETCH -> EXEC), opcode decoder producing datapath
//   selects, a 32-bit ALU and a branch comparator. The FSM state register is the only state;
//   everything else is combinational.
//
// Optional build macro: RV_EXEC_ILLEGAL_HALT_EN
//   Defined   -> extra output `illegal` and a HALT state. Executing an unlisted opcode enters
//                HALT, which can only be left through reset.
//   Undefined -> no `illegal` port; unlisted opcodes execute as a NOP.
//
// Ports
//   clk            in   clock, all state on rising edge
//   rst            in   synchronous reset, active-low
//   stall          in   bus wait; freezes the FSM
//   opcode/f3/f7   in   instruction fields ir[6:0], funct3, funct7
//   alu_a, alu_b   in   ALU operands (muxed outside via alu_in_a_sel / alu_in_b_sel)
//   cmp_a, cmp_b   in   comparator operands (rs1, rs2)
//   alu_out        out  ALU result
//   alu_mode       out  active ALU op
//   comp_result    out  branch condition result
//   alu_in_a_sel   out  0=RS1 1=PC
//   alu_in_b_sel   out  0=RS2 1=IMM
//   dest_reg_from  out  0=NONE 1=ALU 2=BUS 3=NEXT_PC
//   pc_src         out  0=STEP 1=ALU
//   en_comp_unit   out  branch: take imm step when comp_result=1
//   dbus_re/we     out  data-bus read/write request
//   load_ir, en_iaddr, en_pc_counter  out  fetch/sequencing strobes
//   illegal        out  (RV_EXEC_ILLEGAL_HALT_EN only) core halted on an unlisted opcode

module rv_exec_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [6:0]      opcode,
  input  logic [2:0]      f3,
  input  logic [6:0]      f7,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] cmp_a,
  input  logic [XLEN-1:0] cmp_b,
  output logic [XLEN-1:0] alu_out,
  output logic [3:0]      alu_mode,
  output logic            comp_result,
  output logic            alu_in_a_sel,
  output logic            alu_in_b_sel,
  output logic [1:0]      dest_reg_from,
  output logic            pc_src,
  output logic            en_comp_unit,
  output logic            dbus_re,
  output logic            dbus_we,
  output logic            load_ir,
  output logic            en_iaddr,
`ifdef RV_EXEC_ILLEGAL_HALT_EN
  output logic            illegal,
`endif
  output logic            en_pc_counter
);

  // Opcodes
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  // ALU mode encoding
  localparam logic [3:0] ModeAdd   = 4'd0;
  localparam logic [3:0] ModeSub   = 4'd1;
  localparam logic [3:0] ModeSll   = 4'd2;
  localparam logic [3:0] ModeSlt   = 4'd3;
  localparam logic [3:0] ModeSltu  = 4'd4;
  localparam logic [3:0] ModeXor   = 4'd5;
  localparam logic [3:0] ModeSrl   = 4'd6;
  localparam logic [3:0] ModeSra   = 4'd7;
  localparam logic [3:0] ModeOr    = 4'd8;
  localparam logic [3:0] ModeAnd   = 4'd9;
  localparam logic [3:0] ModePassB = 4'd10;

  // Destination register source
  localparam logic [1:0] DestNone   = 2'd0;
  localparam logic [1:0] DestAlu    = 2'd1;
  localparam logic [1:0] DestBus    = 2'd2;
  localparam logic [1:0] DestNextPc = 2'd3;

  typedef enum logic [1:0] {
    StReset,
    StFetch,
    StExec,
    StHalt
  } state_e;

  state_e state_q, state_d;

  logic jalr_fix;    // clear alu_out[0] for JALR targets
  logic unknown_op;  // EXEC saw an opcode outside the supported set

  // funct3 -> ALU mode. `alt` is funct7[5]; it selects SUB only for register-register ops,
  // while SRA is selected by it for both OP and OP-IMM.
  function automatic logic [3:0] f3_mode(input logic [2:0] fn3, input logic alt,
                                         input logic is_reg);
    logic [3:0] m;
    unique case (fn3)
      3'b000:  m = (is_reg && alt) ? ModeSub : ModeAdd;
      3'b001:  m = ModeSll;
      3'b010:  m = ModeSlt;
      3'b011:  m = ModeSltu;
      3'b100:  m = ModeXor;
      3'b101:  m = alt ? ModeSra : ModeSrl;
      3'b110:  m = ModeOr;
      default: m = ModeAnd;
    endcase
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: if (!stall) state_d = StExec;
      StExec: begin
        if (!stall) begin
`ifdef RV_EXEC_ILLEGAL_HALT_EN
          state_d = unknown_op ? StHalt : StFetch;
`else
          state_d = StFetch;
`endif
        end
      end
      default: state_d = state_q;  // StHalt: only reset leaves
    endcase
  end

  // ---------------------------------------------------------------------------
  // Strobes and datapath selects
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_mode      = ModeAdd;
    alu_in_a_sel  = 1'b0;
    alu_in_b_sel  = 1'b0;
    dest_reg_from = DestNone;
    pc_src        = 1'b0;
    en_comp_unit  = 1'b0;
    dbus_re       = 1'b0;
    dbus_we       = 1'b0;
    load_ir       = 1'b0;
    en_iaddr      = 1'b0;
    en_pc_counter = 1'b0;
    jalr_fix      = 1'b0;
    unknown_op    = 1'b0;

    // While rst is low everything stays at its idle value, even mid-instruction.
    if (rst) begin
      unique case (state_q)
        StFetch: begin
          en_iaddr = 1'b1;
          load_ir  = 1'b1;
        end
        StExec: begin
          en_pc_counter = 1'b1;
          case (opcode)
            OpLui: begin
              alu_in_b_sel  = 1'b1;
              alu_mode      = ModePassB;
              dest_reg_from = DestAlu;
            end
            OpAuipc: begin
              alu_in_a_sel  = 1'b1;
              alu_in_b_sel  = 1'b1;
              dest_reg_from = DestAlu;
            end
            OpJal: begin
              alu_in_a_sel  = 1'b1;
              alu_in_b_sel  = 1'b1;
              dest_reg_from = DestNextPc;
              pc_src        = 1'b1;
            end
            OpJalr: begin
              alu_in_b_sel  = 1'b1;
              dest_reg_from = DestNextPc;
              pc_src        = 1'b1;
              jalr_fix      = 1'b1;
            end
            OpBranch: begin
              alu_mode     = ModeSub;
              en_comp_unit = 1'b1;
            end
            OpLoad: begin
              alu_in_b_sel  = 1'b1;
              dest_reg_from = DestBus;
              dbus_re       = 1'b1;
            end
            OpStore: begin
              alu_in_b_sel = 1'b1;
              dbus_we      = 1'b1;
            end
            OpImm: begin
              alu_in_b_sel  = 1'b1;
              alu_mode      = f3_mode(f3, f7[5], 1'b0);
              dest_reg_from = DestAlu;
            end
            OpReg: begin
              alu_mode      = f3_mode(f3, f7[5], 1'b1);
              dest_reg_from = DestAlu;
            end
            default: unknown_op = 1'b1;  // NOP: only the PC advances
          endcase
        end
        default: ;  // StReset / StHalt: all idle
      endcase
    end
  end

`ifdef RV_EXEC_ILLEGAL_HALT_EN
  assign illegal = rst && (state_q == StHalt);
`endif

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;

  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_mode)
      ModeAdd:   alu_res = alu_a + alu_b;
      ModeSub:   alu_res = alu_a - alu_b;
      ModeSll:   alu_res = alu_a << shamt;
      ModeSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ModeSltu:  alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ModeXor:   alu_res = alu_a ^ alu_b;
      ModeSrl:   alu_res = alu_a >> shamt;
      ModeSra:   alu_res = $unsigned($signed(alu_a) >>> shamt);
      ModeOr:    alu_res = alu_a | alu_b;
      ModeAnd:   alu_res = alu_a & alu_b;
      ModePassB: alu_res = alu_b;
      default:   alu_res = '0;
    endcase
  end

  assign alu_out = {alu_res[XLEN-1:1], alu_res[0] & ~jalr_fix};

  // ---------------------------------------------------------------------------
  // Branch comparator
  // ---------------------------------------------------------------------------
  always_comb begin
    comp_result = 1'b0;
    case (f3)
      3'b000:  comp_result = (cmp_a == cmp_b);
      3'b001:  comp_result = (cmp_a != cmp_b);
      3'b100:  comp_result = ($signed(cmp_a) <  $signed(cmp_b));
      3'b101:  comp_result = ($signed(cmp_a) >= $signed(cmp_b));
      3'b110:  comp_result = (cmp_a <  cmp_b);
      3'b111:  comp_result = (cmp_a >= cmp_b);
      default: comp_result = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rv_exec_ctrl.sv
// Scoreboard bench for rv_exec_ctrl: the stimulus process pushes the expected outputs for each
// cycle it drives; a monitor pops and compares them on the falling edge.

module tb_rv_exec_ctrl;

  typedef struct packed {
    logic       ia;
    logic       ir;
    logic       pc;
    logic       asel;
    logic       bsel;
    logic [1:0] dest;
    logic       psrc;
    logic       ecu;
    logic       re;
    logic       we;
    logic [3:0] mode;
  } ctrl_t;

  typedef struct {
    string       name;
    ctrl_t       c;
    bit          chk_alu;
    logic [31:0] alu;
    bit          chk_cmp;
    logic        cmp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] alu_a, alu_b, cmp_a, cmp_b;
  logic [31:0] alu_out;
  logic [3:0]  alu_mode;
  logic        comp_result, alu_in_a_sel, alu_in_b_sel, pc_src, en_comp_unit;
  logic [1:0]  dest_reg_from;
  logic        dbus_re, dbus_we, load_ir, en_iaddr, en_pc_counter;
`ifdef RV_EXEC_ILLEGAL_HALT_EN
  logic        illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rv_exec_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .opcode        (opcode),
    .f3            (f3),
    .f7            (f7),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .cmp_a         (cmp_a),
    .cmp_b         (cmp_b),
    .alu_out       (alu_out),
    .alu_mode      (alu_mode),
    .comp_result   (comp_result),
    .alu_in_a_sel  (alu_in_a_sel),
    .alu_in_b_sel  (alu_in_b_sel),
    .dest_reg_from (dest_reg_from),
    .pc_src        (pc_src),
    .en_comp_unit  (en_comp_unit),
    .dbus_re       (dbus_re),
    .dbus_we       (dbus_we),
    .load_ir       (load_ir),
    .en_iaddr      (en_iaddr),
`ifdef RV_EXEC_ILLEGAL_HALT_EN
    .illegal       (illegal),
`endif
    .en_pc_counter (en_pc_counter)
  );

  function automatic ctrl_t mk(logic ia, logic ir, logic pc, logic asel, logic bsel,
                               logic [1:0] dest, logic psrc, logic ecu, logic re, logic we,
                               logic [3:0] mode);
    ctrl_t c;
    c.ia = ia; c.ir = ir; c.pc = pc; c.asel = asel; c.bsel = bsel; c.dest = dest;
    c.psrc = psrc; c.ecu = ecu; c.re = re; c.we = we; c.mode = mode;
    return c;
  endfunction

  // EXEC-state control word: en_pc_counter set, fetch strobes clear.
  function automatic ctrl_t ex(logic asel, logic bsel, logic [3:0] mode, logic [1:0] dest,
                               logic psrc, logic ecu, logic re, logic we);
    return mk(1'b0, 1'b0, 1'b1, asel, bsel, dest, psrc, ecu, re, we, mode);
  endfunction

  ctrl_t c_zero, c_fetch;

  task automatic push(string name, ctrl_t c, bit chk_alu, logic [31:0] alu, bit chk_cmp,
                      logic cmp);
    exp_t e;
    e.name = name; e.c = c; e.chk_alu = chk_alu; e.alu = alu; e.chk_cmp = chk_cmp; e.cmp = cmp;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One FETCH cycle then EXEC, optionally held in EXEC by nstall stalled cycles.
  task automatic run_instr(string name, logic [6:0] opc, logic [2:0] fn3, logic [6:0] fn7,
                           logic [31:0] a, logic [31:0] b, logic [31:0] ca, logic [31:0] cb,
                           ctrl_t c, bit chk_alu, logic [31:0] alu, bit chk_cmp, logic cmp,
                           int nstall);
    step();
    opcode = opc; f3 = fn3; f7 = fn7; alu_a = a; alu_b = b; cmp_a = ca; cmp_b = cb;
    push({name, "_fetch"}, c_fetch, 1'b0, '0, 1'b0, 1'b0);
    step();
    push(name, c, chk_alu, alu, chk_cmp, cmp);
    if (nstall > 0) begin
      stall = 1'b1;
      for (int i = 0; i < nstall; i++) begin
        step();
        push({name, "_stalled"}, c, chk_alu, alu, chk_cmp, cmp);
      end
      stall = 1'b0;
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t  e;
    ctrl_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = mk(en_iaddr, load_ir, en_pc_counter, alu_in_a_sel, alu_in_b_sel, dest_reg_from,
                 pc_src, en_comp_unit, dbus_re, dbus_we, alu_mode);
        n_checks++;
        if (act !== e.c) begin
          n_fail++;
          $display("FAIL %s ctrl: got %h required %h", e.name, act, e.c);
        end
        if (e.chk_alu) begin
          n_checks++;
          if (alu_out !== e.alu) begin
            n_fail++;
            $display("FAIL %s alu_out: got %h required %h", e.name, alu_out, e.alu);
          end
        end
        if (e.chk_cmp) begin
          n_checks++;
          if (comp_result !== e.cmp) begin
            n_fail++;
            $display("FAIL %s comp_result: got %b required %b", e.name, comp_result, e.cmp);
          end
        end
      end
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    c_zero  = '0;
    c_fetch = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    rst = 1'b0; stall = 1'b0; opcode = '0; f3 = '0; f7 = '0;
    alu_a = '0; alu_b = '0; cmp_a = '0; cmp_b = 32'd1;

    // Reset sequence
    step();
    push("rst_low", c_zero, 1'b0, '0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    push("reset_state", c_zero, 1'b0, '0, 1'b0, 1'b0);
    step();
    push("fetch_first", c_fetch, 1'b0, '0, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      push("fetch_stalled", c_fetch, 1'b0, '0, 1'b0, 1'b0);
    end
    stall = 1'b0;
    step();
    push("exec_nop", ex(0, 0, 4'd0, 2'd0, 0, 0, 0, 0), 1'b0, '0, 1'b0, 1'b0);

    // name, opc, f3, f7, a, b, cmp_a, cmp_b, ctrl, chk_alu, alu, chk_cmp, cmp, nstall
    run_instr("op_sub", 7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7, 0, 0,
              ex(0, 0, 4'd1, 2'd1, 0, 0, 0, 0), 1, 32'hFFFF_FFFE, 0, 0, 0);
    run_instr("op_add", 7'b0110011, 3'b000, 7'b0000000, 32'hFFFF_FFFF, 32'd2, 0, 0,
              ex(0, 0, 4'd0, 2'd1, 0, 0, 0, 0), 1, 32'd1, 0, 0, 0);
    run_instr("srai", 7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 0, 0,
              ex(0, 1, 4'd7, 2'd1, 0, 0, 0, 0), 1, 32'hF800_0000, 0, 0, 0);
    run_instr("sltiu", 7'b0010011, 3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 0, 0,
              ex(0, 1, 4'd4, 2'd1, 0, 0, 0, 0), 1, 32'd1, 0, 0, 0);
    run_instr("slti", 7'b0010011, 3'b010, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 0, 0,
              ex(0, 1, 4'd3, 2'd1, 0, 0, 0, 0), 1, 32'd0, 0, 0, 0);
    run_instr("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 32'd5, 32'd7, 0, 0,
              ex(0, 1, 4'd0, 2'd1, 0, 0, 0, 0), 1, 32'd12, 0, 0, 0);
    run_instr("op_sll", 7'b0110011, 3'b001, 7'b0000000, 32'd1, 32'd33, 0, 0,
              ex(0, 0, 4'd2, 2'd1, 0, 0, 0, 0), 1, 32'd2, 0, 0, 0);
    run_instr("op_srl", 7'b0110011, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 0, 0,
              ex(0, 0, 4'd6, 2'd1, 0, 0, 0, 0), 1, 32'h0800_0000, 0, 0, 0);
    run_instr("op_and", 7'b0110011, 3'b111, 7'b0000000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 0, 0,
              ex(0, 0, 4'd9, 2'd1, 0, 0, 0, 0), 1, 32'h00F0_F000, 0, 0, 0);
    run_instr("blt", 7'b1100011, 3'b100, 7'b0000000, 32'd10, 32'd3, 32'hFFFF_FFFF, 32'd1,
              ex(0, 0, 4'd1, 2'd0, 0, 1, 0, 0), 1, 32'd7, 1, 1'b1, 0);
    run_instr("bgeu", 7'b1100011, 3'b111, 7'b0000000, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1,
              ex(0, 0, 4'd1, 2'd0, 0, 1, 0, 0), 0, '0, 1, 1'b1, 0);
    run_instr("bltu", 7'b1100011, 3'b110, 7'b0000000, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1,
              ex(0, 0, 4'd1, 2'd0, 0, 1, 0, 0), 0, '0, 1, 1'b0, 0);
    run_instr("beq", 7'b1100011, 3'b000, 7'b0000000, 32'd0, 32'd0, 32'h1234, 32'h1234,
              ex(0, 0, 4'd1, 2'd0, 0, 1, 0, 0), 0, '0, 1, 1'b1, 0);
    run_instr("br_f3_010", 7'b1100011, 3'b010, 7'b0000000, 32'd0, 32'd0, 32'd5, 32'd5,
              ex(0, 0, 4'd1, 2'd0, 0, 1, 0, 0), 0, '0, 1, 1'b0, 0);
    run_instr("jalr", 7'b1100111, 3'b000, 7'b0000000, 32'h1001, 32'd2, 0, 0,
              ex(0, 1, 4'd0, 2'd3, 1, 0, 0, 0), 1, 32'h1002, 0, 0, 0);
    run_instr("jal", 7'b1101111, 3'b000, 7'b0000000, 32'h100, 32'hFFFF_FFFC, 0, 0,
              ex(1, 1, 4'd0, 2'd3, 1, 0, 0, 0), 1, 32'h0FC, 0, 0, 0);
    run_instr("lui", 7'b0110111, 3'b000, 7'b0000000, 32'hDEAD_BEEF, 32'h1234_5000, 0, 0,
              ex(0, 1, 4'd10, 2'd1, 0, 0, 0, 0), 1, 32'h1234_5000, 0, 0, 0);
    run_instr("auipc", 7'b0010111, 3'b000, 7'b0000000, 32'h0000_2000, 32'h0001_0000, 0, 0,
              ex(1, 1, 4'd0, 2'd1, 0, 0, 0, 0), 1, 32'h0001_2000, 0, 0, 0);
    run_instr("store", 7'b0100011, 3'b010, 7'b0000000, 32'h100, 32'h8, 0, 0,
              ex(0, 1, 4'd0, 2'd0, 0, 0, 0, 1), 1, 32'h108, 0, 0, 0);
    run_instr("load", 7'b0000011, 3'b010, 7'b0000000, 32'h200, 32'h4, 0, 0,
              ex(0, 1, 4'd0, 2'd2, 0, 0, 1, 0), 1, 32'h204, 0, 0, 2);
    run_instr("nop_unknown", 7'b1111111, 3'b000, 7'b0100000, 32'd1, 32'd1, 0, 0,
              ex(0, 0, 4'd0, 2'd0, 0, 0, 0, 0), 1, 32'd2, 0, 0, 0);

    // Reset while a load is in EXEC: strobes drop immediately and stay low in RESET.
    step();
    opcode = 7'b0000011; f3 = 3'b010; alu_a = 32'h40; alu_b = 32'h4;
    push("pre_rst_fetch", c_fetch, 1'b0, '0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    push("rst_mid_exec", c_zero, 1'b0, '0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    push("after_rst", c_zero, 1'b0, '0, 1'b0, 1'b0);
    step();
    push("refetch", c_fetch, 1'b0, '0, 1'b0, 1'b0);

    // Let the monitor drain the scoreboard.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
